// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's pipeline-facing signals.
// master: fetch stage view. It takes control inputs and the imem read data,
//         and drives the imem address, the IF/ID register, halt status and the stall count.
// slave : environment view (hazard unit, EX redirect, imem, ID stage).
interface fetch_stage_if;
    logic        is_stall;
    logic        flush;
    logic [31:0] target_pc;
    logic        halt_req;
    logic [31:0] imem_dout;
    logic [31:0] imem_addr;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;
    logic        is_halted;
    logic [31:0] stall_cycles;

    modport master (
        input  is_stall, flush, target_pc, halt_req, imem_dout,
        output imem_addr, IF_ID_inst, IF_ID_pc, IF_ID_valid, is_halted, stall_cycles
    );

    modport slave (
        output is_stall, flush, target_pc, halt_req, imem_dout,
        input  imem_addr, IF_ID_inst, IF_ID_pc, IF_ID_valid, is_halted, stall_cycles
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage. It owns the PC and the IF/ID register.
// Fetch always predicts not-taken (PC+4), redirects on an EX flush and injects NOP bubbles.
// On a halting ecall it freezes fetch, drains three downstream stages and then raises is_halted.
// It also keeps a saturating count of stalled RUN cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - fetch_stage_if.master, which carries the control inputs, the imem read port and the IF/ID outputs
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned DRAIN_W = 2;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     if_inst;
    logic [XLEN-1:0]     if_pc;
    logic                if_valid;
    logic                halted;
    logic [XLEN-1:0]     stall_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;

    // PC, IF/ID register, halt sequencing and stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            if_inst   <= NOP;
            if_pc     <= '0;
            if_valid  <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.flush) begin
                        // A redirect overrides halt and stall; the redirect slot becomes a bubble.
                        pc       <= bus.target_pc;
                        if_inst  <= NOP;
                        if_pc    <= '0;
                        if_valid <= 1'b0;
                    end else if (bus.halt_req && !bus.is_stall) begin
                        if_inst   <= NOP;
                        if_pc     <= '0;
                        if_valid  <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else if (bus.is_stall) begin
                        if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + XLEN'(1);
                        end
                    end else begin
                        if_inst  <= bus.imem_dout;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + XLEN'(4);
                    end
                end
                DRAIN: begin
                    // The ecall walks EX/MEM/WB while fetch feeds bubbles.
                    if_inst   <= NOP;
                    if_pc     <= '0;
                    if_valid  <= 1'b0;
                    drain_cnt <= drain_cnt + DRAIN_W'(1);
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.IF_ID_inst   = if_inst;
    assign bus.IF_ID_pc     = if_pc;
    assign bus.IF_ID_valid  = if_valid;
    assign bus.is_halted    = halted;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// The first part applies table-driven vectors, the second part hand-written
// halt and reset sequences, and the third part randomized stimulus compared
// against a cycle-index reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words at 0 and 4, and an address hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_0113;
            default:       return a ^ 32'h1357_9BDF;
        endcase
    endfunction

    fetch_stage_if bus ();
    assign bus.imem_dout = mem_word(bus.imem_addr);

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic [31:0] tp, input logic hr);
        bus.is_stall  = st;
        bus.flush     = fl;
        bus.target_pc = tp;
        bus.halt_req  = hr;
    endtask

    task automatic step(input logic st, input logic fl, input logic [31:0] tp, input logic hr);
        drive(st, fl, tp, hr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  bus.imem_addr, 32'h0);
        chk({tag, "_inst"},  bus.IF_ID_inst, NOP);
        chk({tag, "_pc"},    bus.IF_ID_pc, 32'h0);
        chk({tag, "_valid"}, {31'b0, bus.IF_ID_valid}, 32'h0);
        chk({tag, "_halt"},  {31'b0, bus.is_halted}, 32'h0);
        chk({tag, "_sc"},    bus.stall_cycles, 32'h0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] tpc;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_sc;
    } vec_t;

    vec_t tbl [10];

    // Reference-model state for the randomized phase
    logic [31:0] m_pc, m_inst, m_ifpc, m_sc;
    logic        m_valid;
    int          halt_at, cyc;
    logic        st, fl, hr;
    logic [31:0] tp;
    logic        exp_halted;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        tbl[0] = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h0050_0093, 32'h0,         1'b1, 32'd0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,         32'h8,         32'h0010_0113, 32'h4,         1'b1, 32'd0};
        tbl[2] = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h0010_0113, 32'h4,         1'b1, 32'd1};
        tbl[3] = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h0010_0113, 32'h4,         1'b1, 32'd2};
        tbl[4] = '{1'b0, 1'b0, 32'h0,         32'hC,         32'h1357_9BD7, 32'h8,         1'b1, 32'd2};
        tbl[5] = '{1'b1, 1'b1, 32'h40,        32'h40,        NOP,           32'h0,         1'b0, 32'd2};
        tbl[6] = '{1'b0, 1'b0, 32'h0,         32'h44,        32'h1357_9B9F, 32'h40,        1'b1, 32'd2};
        tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,           32'h0,         1'b0, 32'd2};
        tbl[8] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'hECA8_6423, 32'hFFFF_FFFC, 1'b1, 32'd2};
        tbl[9] = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h0050_0093, 32'h0,         1'b1, 32'd2};

        // Table-driven vectors: fetch, stall, flush-over-stall and PC wrap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].stall, tbl[i].flush, tbl[i].tpc, 1'b0);
            chk($sformatf("v%0d_addr", i),  bus.imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_inst", i),  bus.IF_ID_inst, tbl[i].e_inst);
            chk($sformatf("v%0d_pc", i),    bus.IF_ID_pc, tbl[i].e_pc);
            chk($sformatf("v%0d_valid", i), {31'b0, bus.IF_ID_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("v%0d_sc", i),    bus.stall_cycles, tbl[i].e_sc);
            chk($sformatf("v%0d_halt", i),  {31'b0, bus.is_halted}, 32'h0);
        end

        // A halt request while stalled is refused, then a halt is accepted and drained.
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("hstall_addr", bus.imem_addr, 32'h0);
        chk("hstall_sc", bus.stall_cycles, 32'd1);
        chk("hstall_halt", {31'b0, bus.is_halted}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("hstall_inst", bus.IF_ID_inst, 32'h0050_0093);
        chk("hstall_addr2", bus.imem_addr, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1);                  // accepted in cycle t
        chk("h1_addr", bus.imem_addr, 32'h4);
        chk("h1_inst", bus.IF_ID_inst, NOP);
        chk("h1_valid", {31'b0, bus.IF_ID_valid}, 32'h0);
        chk("h1_halt", {31'b0, bus.is_halted}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("h2_halt", {31'b0, bus.is_halted}, 32'h0);
        step(1'b0, 1'b1, 32'h80, 1'b0);                 // flush in t+2 is ignored
        chk("h3_addr", bus.imem_addr, 32'h4);
        chk("h3_inst", bus.IF_ID_inst, NOP);
        chk("h3_halt", {31'b0, bus.is_halted}, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("h4_halt", {31'b0, bus.is_halted}, 32'h1);
        chk("h4_sc", bus.stall_cycles, 32'd1);
        chk("h4_addr", bus.imem_addr, 32'h4);
        step(1'b1, 1'b1, 32'h80, 1'b1);
        chk("h5_halt", {31'b0, bus.is_halted}, 32'h1);
        chk("h5_addr", bus.imem_addr, 32'h4);
        chk("h5_sc", bus.stall_cycles, 32'd1);
        chk("h5_valid", {31'b0, bus.IF_ID_valid}, 32'h0);

        // Asserting reset mid-DRAIN clears the state without a clock edge.
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_vals("rdrain");
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rd_inst", bus.IF_ID_inst, 32'h0050_0093);
        chk("rd_addr", bus.imem_addr, 32'h4);
        chk("rd_valid", {31'b0, bus.IF_ID_valid}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk($sformatf("rd_halt%0d", i), {31'b0, bus.is_halted}, 32'h0);
        end

        // Randomized run against the reference model
        for (int r = 0; r < 5; r++) begin
            do_reset();
            m_pc = 32'h0; m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0; m_sc = 32'h0;
            halt_at = -1; cyc = 0;
            for (int i = 0; i < 300; i++) begin
                st = ($urandom_range(0, 3) == 0);
                fl = ($urandom_range(0, 7) == 0);
                tp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                hr = ($urandom_range(0, 59) == 0);
                if (halt_at < 0) begin
                    if (fl) begin
                        m_pc = tp; m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
                    end else if (hr && !st) begin
                        halt_at = cyc; m_inst = NOP; m_valid = 1'b0;
                    end else if (st) begin
                        if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
                    end else begin
                        m_inst = mem_word(m_pc); m_ifpc = m_pc; m_valid = 1'b1;
                        m_pc = m_pc + 32'd4;
                    end
                end
                step(st, fl, tp, hr);
                cyc++;
                exp_halted = (halt_at >= 0) && (cyc >= halt_at + 4);
                chk("rnd_addr", bus.imem_addr, m_pc);
                chk("rnd_inst", bus.IF_ID_inst, m_inst);
                chk("rnd_valid", {31'b0, bus.IF_ID_valid}, {31'b0, m_valid});
                chk("rnd_sc", bus.stall_cycles, m_sc);
                chk("rnd_halt", {31'b0, bus.is_halted}, {31'b0, exp_halted});
                if (halt_at < 0) chk("rnd_pc", bus.IF_ID_pc, m_ifpc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC register and the IF/ID pipeline register, directly upstream of the ID-stage hazard detection unit whose `is_stall` it consumes. Fetch is always-not-taken (PC+4), redirects on EX-resolved flushes, and injects NOP bubbles. A small FSM freezes fetch on a halting ecall, drains the pipeline and raises `is_halted`. A saturating counter exposes stall cycles for performance checks.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP`, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — asynchronous, active-low (0 = reset asserted, acts immediately, no clock needed)
- `is_stall` input 1 — from hazard detection unit; hold PC and IF/ID
- `flush` input 1 — EX-stage misprediction redirect
- `target_pc` input 32 — redirect address, valid with `flush`
- `halt_req` input 1 — ID holds a halting ecall (x17==10 resolved)
- `imem_dout` input 32 — instruction at `imem_addr`, combinational memory read
- `imem_addr` output 32 — current PC, combinational from PC register
- `IF_ID_inst` output 32 — registered instruction to ID
- `IF_ID_pc` output 32 — registered PC of `IF_ID_inst`
- `IF_ID_valid` output 1 — 0 when `IF_ID_inst` is an injected bubble
- `is_halted` output 1 — registered; 1 once pipeline drained after halt
- `stall_cycles` output 32 — saturating count of stalled RUN cycles

## Operation
- Reset values: PC=`RESET_PC`, `IF_ID_inst`=`NOP`, `IF_ID_pc`=0, `IF_ID_valid`=0, `is_halted`=0, `stall_cycles`=0, state=RUN, drain count=0.
- States: RUN, DRAIN, HALTED.
- RUN, per-edge priority (highest first):
  - `flush`: PC<=`target_pc`; IF/ID<=`NOP`, valid 0, `IF_ID_pc`<=0; stall counter not incremented; `halt_req`/`is_stall` ignored.
  - `halt_req` && !`is_stall`: PC held; IF/ID<=`NOP`/valid 0; state->DRAIN, count<=0.
  - `is_stall`: PC and all IF/ID outputs held; `stall_cycles`++ (saturates at 32'hFFFF_FFFF). `halt_req` while stalled is not accepted.
  - else: `IF_ID_inst`<=`imem_dout`, `IF_ID_pc`<=PC, valid<=1, PC<=PC+4 (modulo 2^32; 0xFFFF_FFFC -> 0x0000_0000).
- DRAIN: PC frozen; IF/ID forced `NOP`/valid 0; `flush`, `is_stall`, `halt_req` ignored (no older instruction can still redirect). Count increments each edge; edge with count==2 -> HALTED.
- HALTED: everything frozen; `is_halted`=1; all inputs ignored; leaves only via reset.
- `stall_cycles` increments only in RUN.
- Reset asserted at any time (including mid-DRAIN) returns all state to reset values asynchronously.

## Timing
- Fetch latency: instruction at PC in cycle t appears on `IF_ID_inst` after edge ending t.
- Flush: `target_pc` seen in cycle t -> `imem_addr`=`target_pc` in t+1; its instruction reaches IF/ID after t+1 edge (one bubble).
- Halt accepted in cycle t (ecall in ID): ecall in EX t+1, MEM t+2, WB t+3; `is_halted`=1 from cycle t+4.
- Stall: hold is exact; no instruction dropped or duplicated across any stall length.
- No combinational path from inputs to outputs except none (`imem_addr` from PC reg only).

## Test plan
- Reset release, `RESET_PC`=0, imem[0]=0x0050_0093, imem[4]=0x0010_0113 -> after edge 1 `IF_ID_inst`=0x0050_0093, `IF_ID_pc`=0, valid 1, `imem_addr`=4; after edge 2 `IF_ID_inst`=0x0010_0113.
- PC=8, `is_stall`=1 for 2 cycles -> `imem_addr` stays 8, IF/ID unchanged, `stall_cycles`=2; next free edge fetches imem[8].
- `flush`=1 with `is_stall`=1, `target_pc`=0x40 -> IF/ID=0x0000_0013, valid 0, `imem_addr`=0x40, `stall_cycles` unchanged.
- `halt_req`=1, `is_stall`=0 at cycle t -> `imem_addr` frozen, IF/ID NOP, `is_halted` 0 in t+1..t+3, 1 at t+4; `flush`=1 with `target_pc`=0x80 in t+2 has no effect.
- PC=0xFFFF_FFFC, no stall -> next `imem_addr`=0x0000_0000, `IF_ID_pc`=0xFFFF_FFFC.
- `reset` driven 0 mid-cycle during DRAIN -> outputs return to reset values immediately without a clock edge; after release normal fetch from `RESET_PC`, `is_halted`=0.
